// File: rtl/lcg_stim_pkg.sv
// Shared constants and FSM state type for the LCG stimulus generator.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MULT     = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC      = 32'h0000_3039;
  localparam logic [31:0] DEFAULT_SEED = 32'h8A50_06C1;
  localparam int unsigned STIM_WIDTH   = 136;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_OFFER,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lcg_stim_gen_step.sv
// One combinational LCG step; the product is truncated to 32 bits (mod 2^32).
module lcg_step
  import lcg_stim_pkg::*;
(
  input  logic [31:0] state_i,
  output logic [31:0] next_o
);

  always_comb begin
    next_o = state_i * LCG_MULT + LCG_INC;
  end

endmodule

// File: rtl/lcg_stim_gen.sv
// Generates STIM_WIDTH-bit stimulus vectors from a 32-bit LCG, one 32-bit lane
// per clock, and offers each vector on a valid/ready handshake.
module lcg_stim_gen #(
  parameter int unsigned STIM_WIDTH   = lcg_stim_pkg::STIM_WIDTH,
  parameter logic [31:0] DEFAULT_SEED = lcg_stim_pkg::DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  seed_load,
  input  logic [31:0]           seed_in,
  input  logic [31:0]           cycles_in,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic [STIM_WIDTH-1:0] vec_data,
  output logic                  busy,
  output logic                  done
);
  import lcg_stim_pkg::*;

  state_e                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic [32:0]             rem_q, rem_d;
  logic [31:0]             lcg_q, lcg_d;
  logic [31:0]             lcg_next;
  logic [STIM_WIDTH-1:0]   vec_q, vec_d;

  lcg_step u_lcg_step (
    .state_i (lcg_q),
    .next_o  (lcg_next)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rem_d   = rem_q;
    lcg_d   = lcg_q;
    vec_d   = vec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // 33-bit count of vectors still to deliver: cycles_in + 1 cannot wrap
          rem_d   = {1'b0, cycles_in} + 33'd1;
          lcg_d   = seed_load ? seed_in : DEFAULT_SEED;
          step_d  = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        lcg_d = lcg_next;
        case (step_q)
          3'd0:    vec_d[31:0]    = lcg_next;
          3'd1:    vec_d[63:32]   = lcg_next;
          3'd2:    vec_d[95:64]   = lcg_next;
          3'd3:    vec_d[127:96]  = lcg_next;
          default: vec_d[135:128] = lcg_next[7:0];
        endcase
        if (step_q == 3'd4) begin
          state_d = ST_OFFER;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_OFFER: begin
        if (vec_ready) begin
          rem_d = rem_q - 33'd1;
          if (rem_q == 33'd1) begin
            state_d = ST_DONE;
          end else begin
            step_d  = '0;
            state_d = ST_GEN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      rem_q   <= '0;
      lcg_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      lcg_q   <= lcg_d;
      vec_q   <= vec_d;
    end
  end

  assign vec_valid = (state_q == ST_OFFER);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign vec_data  = vec_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Directed bench for lcg_stim_gen: a table of runs plus hand-written reset sequence.
`timescale 1ns/1ps
module tb_lcg_stim_gen;

  logic         clk = 1'b0;
  logic         rst_n, start, seed_load, vec_ready;
  logic [31:0]  seed_in, cycles_in;
  logic         vec_valid, busy, done;
  logic [135:0] vec_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] SEED_DEF = 32'h8A50_06C1;

  typedef enum int {RDY_ALWAYS, RDY_HOLD10, RDY_TOGGLE} rdy_mode_e;

  typedef struct {
    string       name;
    bit          sl;
    logic [31:0] seed;
    logic [31:0] cyc;
    rdy_mode_e   mode;
    bit          inject;
  } run_t;

  run_t runs[5];

  always #5 clk = ~clk;

  lcg_stim_gen #(
    .STIM_WIDTH   (136),
    .DEFAULT_SEED (32'h8A50_06C1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .cycles_in (cycles_in),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sw_lcg(input logic [31:0] s);
    logic [63:0] p;
    p = {32'd0, s} * 64'd1103515245 + 64'd12345;
    return p[31:0];
  endfunction

  task automatic next_vec(input logic [31:0] s_in, output logic [31:0] s_out,
                          output logic [135:0] v);
    logic [31:0] s;
    s = s_in;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      s = sw_lcg(s);
      v[32*k +: 32] = s;
    end
    s = sw_lcg(s);
    v[135:128] = s[7:0];
    s_out = s;
  endtask

  task automatic do_run(input run_t r, output logic [135:0] first_vec);
    logic [31:0]  st;
    logic [135:0] exp_v, held;
    int  nvec, v, low, hold;
    bit  fin, inj_active;
    st = r.sl ? r.seed : SEED_DEF;
    nvec = int'(r.cyc) + 1;
    v = 0; low = 0; hold = 0; fin = 0; inj_active = 0;
    first_vec = '0; held = '0;
    @(negedge clk);
    start = 1'b1; seed_load = r.sl; seed_in = r.seed; cycles_in = r.cyc;
    vec_ready = (r.mode == RDY_HOLD10) ? 1'b0 : 1'b1;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0; seed_in = 32'h0BAD_0BAD; cycles_in = 32'd7;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (inj_active) begin
        start = 1'b0; seed_load = 1'b0; inj_active = 0;
      end
      if (done) begin
        chk($sformatf("%s vec_count_at_done", r.name), v, nvec);
        chk($sformatf("%s busy_in_done", r.name), busy, 1'b1);
        chk($sformatf("%s valid_in_done", r.name), vec_valid, 1'b0);
        @(negedge clk);
        chk($sformatf("%s done_one_cycle", r.name), done, 1'b0);
        chk($sformatf("%s busy_after_done", r.name), busy, 1'b0);
        fin = 1;
      end else if (v == nvec) begin
        chk($sformatf("%s done_after_last", r.name), done, 1'b1);
        fin = 1;
      end else if (vec_valid) begin
        if (hold == 0) begin
          chk($sformatf("%s v%0d low_cycles", r.name, v), low, 5);
          next_vec(st, st, exp_v);
          chk($sformatf("%s v%0d data", r.name, v), vec_data, exp_v);
          if (v == 0) first_vec = vec_data;
          held = vec_data;
        end else begin
          chk($sformatf("%s v%0d held_data", r.name, v), vec_data, held);
        end
        case (r.mode)
          RDY_HOLD10: vec_ready = (hold >= 10);
          RDY_TOGGLE: vec_ready = ~vec_ready;
          default:    vec_ready = 1'b1;
        endcase
        hold++;
        if (vec_ready) begin
          v++; hold = 0; low = 0;
        end
      end else begin
        if (hold != 0) begin
          chk($sformatf("%s valid_dropped", r.name), vec_valid, 1'b1);
          hold = 0;
        end
        low++;
        if (r.mode == RDY_TOGGLE) vec_ready = ~vec_ready;
        if (r.inject && v == 0 && low == 2) begin
          start = 1'b1; seed_load = 1'b1; seed_in = 32'h1357_9BDF; cycles_in = 32'd9;
          inj_active = 1;
        end
      end
    end
    chk($sformatf("%s run_complete", r.name), fin, 1'b1);
    vec_ready = 1'b0;
  endtask

  initial begin
    logic [135:0] fv;
    bit           stray;
    rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed_in = '0; cycles_in = '0;
    vec_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {vec_valid, busy, done}, 3'b000);
    chk("reset_data", vec_data, '0);
    rst_n = 1'b1;

    runs[0] = '{"seed0_one",    1'b1, 32'h0000_0000, 32'd0, RDY_ALWAYS, 1'b0};
    runs[1] = '{"default_four", 1'b0, 32'h0000_1234, 32'd3, RDY_ALWAYS, 1'b0};
    runs[2] = '{"backpressure", 1'b1, 32'hDEAD_BEEF, 32'd0, RDY_HOLD10, 1'b0};
    runs[3] = '{"start_in_gen", 1'b0, 32'h0000_0000, 32'd1, RDY_ALWAYS, 1'b1};
    runs[4] = '{"toggle_ready", 1'b1, 32'h0000_0005, 32'd1, RDY_TOGGLE, 1'b0};

    for (int i = 0; i < 5; i++) begin
      do_run(runs[i], fv);
      if (i == 0) begin
        chk("seed0 lane0", fv[31:0], 32'h0000_3039);
        chk("seed0 lane1", fv[63:32], 32'hD3DC_167E);
      end
    end

    // Abort a run with reset while GEN is on step 2.
    @(negedge clk);
    start = 1'b1; seed_load = 1'b1; seed_in = '0; cycles_in = '0; vec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort ctrl", {vec_valid, busy, done}, 3'b000);
    chk("abort data", vec_data, '0);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (vec_valid || busy || done) stray = 1;
    end
    chk("abort stays_idle", stray, 1'b0);
    vec_ready = 1'b0;
    do_run(runs[0], fv);
    chk("rerun lane0", fv[31:0], 32'h0000_3039);
    chk("rerun lane1", fv[63:32], 32'hD3DC_167E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
